// File: rtl/matrix_inv3_seq.sv
// matrix_inv3_seq: sequential 3x3 signed matrix inverter.
//   Accepts one matrix, registers its cofactors, then its determinant, then
//   runs one shared restoring divider over the nine elements in row-major order.
//   Each result is b_ij = cof_ji * 2^FRAC_BITS / det, rounded toward zero.
// Build option: MATINV_SAT_EN. When it is defined, overflowing elements
//   saturate. When it is undefined, they wrap to their low OUT_W bits.
//   The ovf flags are the same in both builds.
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   input handshake; a_flat is row-major, a11 in the LSBs
//   out_valid / out_ready output handshake; b_flat is row-major, b11 in the LSBs
//   det, singular, ovf    determinant, det==0 flag, per-element overflow flags
//   dbg_state_o           current FSM state
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. Once raised, out_valid and the result stay stable until
//   out_ready is seen. in_ready is high only in IDLE.
module matrix_inv3_seq #(
  parameter int DATA_W    = 8,
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [9*DATA_W-1:0]   a_flat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [9*OUT_W-1:0]    b_flat,
  output logic [3*DATA_W+1:0]   det,
  output logic                  singular,
  output logic [8:0]            ovf,
  output logic [2:0]            dbg_state_o
);
  localparam int COF_W = 2*DATA_W+1;
  localparam int DET_W = 3*DATA_W+2;
  localparam int N     = COF_W+FRAC_BITS;
  localparam int CNT_W = $clog2(N);
  localparam logic [N:0] LIM_POS = {{(N+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [N:0] LIM_NEG = LIM_POS + 1'b1;

  typedef enum logic [2:0] {IDLE, COF, DET, DIV, DONE} state_t;

  state_t                   state_q;
  logic                     det_ph_q;
  logic signed [DATA_W-1:0] a_q [9];
  logic signed [COF_W-1:0]  cof_q [9];
  logic signed [DET_W-1:0]  det_w_q;
  logic [DET_W-1:0]         rem_q;
  logic [N-1:0]             dvd_q, quo_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [3:0]               k_q;
  logic                     neg_q;
  logic [OUT_W-1:0]         b_wk_q [9];
  logic [8:0]               ovf_wk_q;
  logic                     in_ready_q, out_valid_q, sing_q;
  logic [9*OUT_W-1:0]       b_q;
  logic [DET_W-1:0]         det_q;
  logic [8:0]               ovf_q;

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign b_flat      = b_q;
  assign det         = det_q;
  assign singular    = sing_q;
  assign ovf         = ovf_q;
  assign dbg_state_o = state_q;

  // Cofactors by cyclic index rotation. The rotation already carries the
  // (-1)^(i+j) sign, so no explicit negation is needed.
  logic signed [COF_W-1:0] ax [9];
  logic signed [COF_W-1:0] cof_d [9];
  always_comb begin
    for (int e = 0; e < 9; e++) ax[e] = COF_W'(a_q[e]);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        cof_d[i*3+j] = ax[((i+1)%3)*3+(j+1)%3] * ax[((i+2)%3)*3+(j+2)%3]
                     - ax[((i+1)%3)*3+(j+2)%3] * ax[((i+2)%3)*3+(j+1)%3];
      end
    end
  end

  // Determinant expanded along row 1, computed exactly at DET_W.
  logic signed [DET_W-1:0] det_d;
  always_comb begin
    det_d = DET_W'(a_q[0]) * DET_W'(cof_q[0])
          + DET_W'(a_q[1]) * DET_W'(cof_q[1])
          + DET_W'(a_q[2]) * DET_W'(cof_q[2]);
  end

  logic [DET_W-1:0] abs_det;
  assign abs_det = det_w_q[DET_W-1] ? DET_W'(-det_w_q) : DET_W'(det_w_q);

  // Operand for the element that starts next. Element k of b uses the
  // transposed cofactor, which is (k%3)*3 + k/3.
  logic [3:0]              ld_k;
  logic signed [COF_W-1:0] ld_cof;
  logic [COF_W-1:0]        ld_abs;
  logic [N-1:0]            ld_dvd;
  logic                    ld_neg;
  always_comb begin
    ld_k   = (state_q == DET) ? 4'd0 : k_q + 4'd1;
    ld_cof = cof_q[0];
    for (int e = 0; e < 9; e++) begin
      if (int'(ld_k) == e) ld_cof = cof_q[(e%3)*3 + e/3];
    end
    ld_abs = ld_cof[COF_W-1] ? COF_W'(-ld_cof) : COF_W'(ld_cof);
    ld_dvd = {ld_abs, {FRAC_BITS{1'b0}}};
    ld_neg = ld_cof[COF_W-1] ^ det_w_q[DET_W-1];
  end

  // One restoring-divide step. A borrow out of the trial subtraction means
  // the quotient bit is 0 and the remainder is kept.
  logic [DET_W:0]   rem_sh, rem_sub;
  logic             q_bit;
  logic [N-1:0]     quo_nx;
  logic [OUT_W-1:0] wrap_val, el_val;
  logic             ovf_el;
  always_comb begin
    rem_sh   = {rem_q, dvd_q[N-1]};
    rem_sub  = rem_sh - {1'b0, abs_det};
    q_bit    = ~rem_sub[DET_W];
    quo_nx   = {quo_q[N-2:0], q_bit};
    wrap_val = neg_q ? -quo_nx[OUT_W-1:0] : quo_nx[OUT_W-1:0];
    ovf_el   = neg_q ? ({1'b0, quo_nx} > LIM_NEG) : ({1'b0, quo_nx} > LIM_POS);
`ifdef MATINV_SAT_EN
    if (ovf_el) el_val = neg_q ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    else        el_val = wrap_val;
`else
    el_val = wrap_val;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      det_ph_q    <= 1'b0;
      det_w_q     <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      neg_q       <= 1'b0;
      ovf_wk_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sing_q      <= 1'b0;
      b_q         <= '0;
      det_q       <= '0;
      ovf_q       <= '0;
      for (int e = 0; e < 9; e++) begin
        a_q[e]    <= '0;
        cof_q[e]  <= '0;
        b_wk_q[e] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            for (int e = 0; e < 9; e++) a_q[e] <= a_flat[e*DATA_W +: DATA_W];
            in_ready_q <= 1'b0;
            state_q    <= COF;
          end
        end
        COF: begin
          for (int e = 0; e < 9; e++) cof_q[e] <= cof_d[e];
          det_ph_q <= 1'b0;
          state_q  <= DET;
        end
        DET: begin
          // First cycle registers det. Second cycle branches on it.
          if (!det_ph_q) begin
            det_w_q  <= det_d;
            det_ph_q <= 1'b1;
          end else begin
            det_ph_q <= 1'b0;
            if (det_w_q == '0) begin
              b_q         <= '0;
              ovf_q       <= '0;
              sing_q      <= 1'b1;
              det_q       <= det_w_q;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              rem_q   <= '0;
              dvd_q   <= ld_dvd;
              quo_q   <= '0;
              cnt_q   <= '0;
              k_q     <= '0;
              neg_q   <= ld_neg;
              state_q <= DIV;
            end
          end
        end
        DIV: begin
          rem_q <= q_bit ? rem_sub[DET_W-1:0] : rem_sh[DET_W-1:0];
          dvd_q <= dvd_q << 1;
          quo_q <= quo_nx;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N-1)) begin
            b_wk_q[k_q]   <= el_val;
            ovf_wk_q[k_q] <= ovf_el;
            if (k_q == 4'd8) begin
              for (int e = 0; e < 8; e++) b_q[e*OUT_W +: OUT_W] <= b_wk_q[e];
              b_q[8*OUT_W +: OUT_W] <= el_val;
              ovf_q       <= {ovf_el, ovf_wk_q[7:0]};
              sing_q      <= 1'b0;
              det_q       <= det_w_q;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              k_q   <= ld_k;
              rem_q <= '0;
              dvd_q <= ld_dvd;
              quo_q <= '0;
              cnt_q <= '0;
              neg_q <= ld_neg;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_inv3_seq.sv
// tb_matrix_inv3_seq: directed bench for matrix_inv3_seq at default parameters.
// Expected results were worked out by hand and are queued before each matrix
// is sent in.
module tb_matrix_inv3_seq;
  localparam int DATA_W    = 8;
  localparam int OUT_W     = 16;
  localparam int FRAC_BITS = 8;
  localparam int DET_W     = 3*DATA_W+2;
  localparam int N         = 2*DATA_W+1+FRAC_BITS;
  localparam int LAT       = 3+9*N;
  localparam int RW        = 9+1+DET_W+9*OUT_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid, in_ready, out_valid, out_ready, singular;
  logic [9*DATA_W-1:0]  a_flat;
  logic [9*OUT_W-1:0]   b_flat;
  logic [DET_W-1:0]     det;
  logic [8:0]           ovf;
  logic [2:0]           dbg_state;

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] cur_exp;

  matrix_inv3_seq #(.DATA_W(DATA_W), .OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a_flat(a_flat),
    .out_valid(out_valid), .out_ready(out_ready), .b_flat(b_flat), .det(det),
    .singular(singular), .ovf(ovf), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9*DATA_W-1:0] mk_a(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    int v[9];
    logic [9*DATA_W-1:0] r;
    v = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
    for (int i = 0; i < 9; i++) r[i*DATA_W +: DATA_W] = DATA_W'(v[i]);
    return r;
  endfunction

  function automatic logic [9*OUT_W-1:0] mk_b(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    int v[9];
    logic [9*OUT_W-1:0] r;
    v = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
    for (int i = 0; i < 9; i++) r[i*OUT_W +: OUT_W] = OUT_W'(v[i]);
    return r;
  endfunction

  task automatic push_exp(input logic [9*OUT_W-1:0] b, input int d, input logic s, input logic [8:0] o);
    exp_q.push_back({o, s, DET_W'(d), b});
  endtask

  // driver: present a matrix, scramble the inputs after accept, wait for the result
  task automatic run_matrix(input string tag, input logic [9*DATA_W-1:0] a, input int exp_lat);
    int cyc;
    logic [95:0] junk;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, in_ready, 1'b1);
    a_flat   = a;
    in_valid = 1'b1;
    @(posedge clk); #1;
    junk   = {$urandom(), $urandom(), $urandom()};
    a_flat = junk[9*DATA_W-1:0];
    check({tag, "_in_ready_busy"}, in_ready, 1'b0);
    cyc = 1;
    while (!out_valid && cyc < 1000) begin
      if (cyc == 2) in_valid = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, cyc - 1, exp_lat);
    cur_exp = exp_q.pop_front();
    check({tag, "_b_flat"}, b_flat, cur_exp[9*OUT_W-1:0]);
    check({tag, "_det"}, det, cur_exp[9*OUT_W +: DET_W]);
    check({tag, "_singular"}, singular, cur_exp[9*OUT_W+DET_W]);
    check({tag, "_ovf"}, ovf, cur_exp[RW-1 -: 9]);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, out_valid, 1'b0);
    check({tag, "_in_ready_rise"}, in_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_flat = '0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_b_flat", b_flat, '0);
    check("rst_det", det, '0);
    check("rst_singular", singular, 1'b0);
    check("rst_ovf", ovf, '0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // identity
    push_exp(mk_b(256, 0, 0, 0, 256, 0, 0, 0, 256), 1, 1'b0, 9'h000);
    run_matrix("ident", mk_a(1, 0, 0, 0, 1, 0, 0, 0, 1), LAT);
    handshake("ident");

    // singular
    push_exp('0, 0, 1'b1, 9'h000);
    run_matrix("sing", mk_a(1, 0, 1, 0, 1, 0, 1, 0, 1), 3);
    handshake("sing");

    // diagonals, including negative det and rounding toward zero
    push_exp(mk_b(128, 0, 0, 0, 64, 0, 0, 0, 32), 64, 1'b0, 9'h000);
    run_matrix("diag248", mk_a(2, 0, 0, 0, 4, 0, 0, 0, 8), LAT);
    handshake("diag248");
    push_exp(mk_b(-128, 0, 0, 0, 256, 0, 0, 0, 256), -2, 1'b0, 9'h000);
    run_matrix("diagm2", mk_a(-2, 0, 0, 0, 1, 0, 0, 0, 1), LAT);
    handshake("diagm2");
    push_exp(mk_b(-85, 0, 0, 0, 256, 0, 0, 0, 256), -3, 1'b0, 9'h000);
    run_matrix("diagm3", mk_a(-3, 0, 0, 0, 1, 0, 0, 0, 1), LAT);
    handshake("diagm3");

    // overflow on b13
`ifdef MATINV_SAT_EN
    push_exp(mk_b(256, -32512, 32767, 0, 256, -32512, 0, 0, 256), 1, 1'b0, 9'h004);
`else
    push_exp(mk_b(256, -32512, 256, 0, 256, -32512, 0, 0, 256), 1, 1'b0, 9'h004);
`endif
    run_matrix("ovf", mk_a(1, 127, 0, 0, 1, 127, 0, 0, 1), LAT);
    handshake("ovf");

    // hold in DONE, then a back-to-back second matrix
    push_exp(mk_b(256, -256, 0, 0, 256, 0, 0, 0, 256), 1, 1'b0, 9'h000);
    run_matrix("hold", mk_a(1, 1, 0, 0, 1, 0, 0, 0, 1), LAT);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_b_flat", b_flat, cur_exp[9*OUT_W-1:0]);
    end
    handshake("hold");
    push_exp(mk_b(0, 256, 0, 256, 0, 0, 0, 0, 256), -1, 1'b0, 9'h000);
    run_matrix("b2b", mk_a(0, 1, 0, 1, 0, 0, 0, 0, 1), LAT);
    handshake("b2b");

    // reset while dividing element k=4
    @(negedge clk);
    a_flat = mk_a(1, 0, 0, 0, 1, 0, 0, 0, 1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3+4*N+5) @(posedge clk);
    #1;
    check("midrst_state_div", dbg_state, 3'd3);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_b_flat", b_flat, '0);
    check("midrst_det", det, '0);
    check("midrst_ovf", ovf, '0);
    check("midrst_state_idle", dbg_state, 3'd0);
    @(negedge clk); rst = 1'b0;
    push_exp(mk_b(256, 0, 0, 0, 256, 0, 0, 0, 256), 1, 1'b0, 9'h000);
    run_matrix("postrst", mk_a(1, 0, 0, 0, 1, 0, 0, 0, 1), LAT);
    handshake("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
